alu_seq_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 66 ++++++
 rtl/alu_seq_iter.sv | 83 ++++++++
 rtl/alu_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ctrl_pkg : opcodes, ALU encodings, FSM states and control tuples for   |
// |                the ALU sequencer.                                          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_SLT = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_NOR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_DIV = 4'd8;
   localparam logic [3:0] OP_REM = 4'd9;

   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_OR   = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_LESS = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_EXEC = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_DIV  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef struct packed {
      logic       ainvert;
      logic       binvert;
      logic       carryin;
      logic [2:0] operation;
   } alu_ctrl_t;

   localparam alu_ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, ALU_AND};
   localparam alu_ctrl_t CTRL_AND  = '{1'b0, 1'b0, 1'b0, ALU_AND};
   localparam alu_ctrl_t CTRL_OR   = '{1'b0, 1'b0, 1'b0, ALU_OR};
   localparam alu_ctrl_t CTRL_ADD  = '{1'b0, 1'b0, 1'b0, ALU_ADD};
   localparam alu_ctrl_t CTRL_SUB  = '{1'b0, 1'b1, 1'b1, ALU_ADD};
   localparam alu_ctrl_t CTRL_SLT  = '{1'b0, 1'b1, 1'b1, ALU_LESS};
   localparam alu_ctrl_t CTRL_XOR  = '{1'b0, 1'b0, 1'b0, ALU_XOR};
   localparam alu_ctrl_t CTRL_NOR  = '{1'b1, 1'b1, 1'b0, ALU_AND};

   function automatic logic is_single(input logic [3:0] op);
      return (op <= OP_NOR);
   endfunction

   function automatic alu_ctrl_t single_ctrl(input logic [3:0] op);
      case (op)
         OP_AND:  return CTRL_AND;
         OP_OR:   return CTRL_OR;
         OP_ADD:  return CTRL_ADD;
         OP_SUB:  return CTRL_SUB;
         OP_SLT:  return CTRL_SLT;
         OP_XOR:  return CTRL_XOR;
         OP_NOR:  return CTRL_NOR;
         default: return CTRL_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_iter : shift/count register bank for iterative MUL and DIV/REM.    |
// |                DIV/REM stepping exists only with ALU_SEQ_DIV_EN defined.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module alu_seq_iter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step_mul,
   input  logic             step_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] mid_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   // hi = acc/rem, mid = mcand/quo, lo = mplier/divisor
   logic [WIDTH-1:0] hi, mid, lo;
   logic [CW-1:0]    cnt, cnt_nxt;

`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] trial;
   assign trial = {hi[WIDTH-2:0], mid[WIDTH-1]};
`else
   logic unused_div;
   assign unused_div = step_div ^ alu_carryout;
`endif

   assign last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      hi_nxt  = hi;
      mid_nxt = mid;
      lo_nxt  = lo;
      cnt_nxt = cnt;
      if (load) begin
         hi_nxt  = '0;
         mid_nxt = a;
         lo_nxt  = b;
         cnt_nxt = '0;
      end else if (step_mul) begin
         hi_nxt  = alu_result;
         mid_nxt = mid << 1;
         lo_nxt  = lo >> 1;
         cnt_nxt = cnt + 1'b1;
      end
`ifdef ALU_SEQ_DIV_EN
      else if (step_div) begin
         hi_nxt  = alu_carryout ? alu_result : trial;
         mid_nxt = {mid[WIDTH-2:0], alu_carryout};
         cnt_nxt = cnt + 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi  <= '0;
         mid <= '0;
         lo  <= '0;
         cnt <= '0;
      end else begin
         hi  <= hi_nxt;
         mid <= mid_nxt;
         lo  <= lo_nxt;
         cnt <= cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_ctrl : multi-cycle sequencer driving a shared ripple ALU.          |
// |                Define ALU_SEQ_DIV_EN to enable DIV/REM (opcodes 8/9).      |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module alu_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPW-1:0]   req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_ainvert,
   output logic             alu_binvert,
   output logic             alu_carryin,
   output logic [2:0]       alu_operation,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_err
);

   logic [2:0]       state, state_nxt;
   logic             accept, w_single, w_mul, w_div;
   logic             iter_load, last;
   logic [WIDTH-1:0] hi_nxt, mid_nxt, lo_nxt;

   alu_ctrl_t        ctrl_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d, res_d;
   logic             err_d, valid_d, ready_d;

   // req_ready is only ever high in IDLE, so no state qualifier is needed
   assign accept   = req_valid & req_ready;
   assign w_single = is_single(req_op);
   assign w_mul    = (req_op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
   logic is_rem;
   assign w_div = (req_op == OP_DIV) || (req_op == OP_REM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         is_rem <= 1'b0;
      else if (accept)
         is_rem <= (req_op == OP_REM);
   end
`else
   assign w_div = 1'b0;
`endif

   assign iter_load = accept & (w_mul | w_div);

   alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (iter_load),
      .step_mul     (state == ST_MUL),
      .step_div     (state == ST_DIV),
      .a            (req_a),
      .b            (req_b),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .hi_nxt       (hi_nxt),
      .mid_nxt      (mid_nxt),
      .lo_nxt       (lo_nxt),
      .last         (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (w_single)
                  state_nxt = ST_EXEC;
               else if (w_mul)
                  state_nxt = ST_MUL;
`ifdef ALU_SEQ_DIV_EN
               else if (w_div && (req_b != '0))
                  state_nxt = ST_DIV;
`endif
               else
                  state_nxt = ST_DONE;
            end
         end
         ST_EXEC: state_nxt = ST_DONE;
         ST_MUL:  if (last) state_nxt = ST_DONE;
`ifdef ALU_SEQ_DIV_EN
         ST_DIV:  if (last) state_nxt = ST_DONE;
`endif
         ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ALU lines are registered, so they are decoded from the state being entered
   always_comb begin
      ctrl_d  = CTRL_NONE;
      alu_a_d = '0;
      alu_b_d = '0;
      res_d   = resp_result;
      err_d   = resp_err;
      valid_d = (state_nxt == ST_DONE);
      ready_d = (state == ST_IDLE) && (state_nxt == ST_IDLE);

      case (state_nxt)
         ST_EXEC: begin
            alu_a_d = req_a;
            alu_b_d = req_b;
            ctrl_d  = single_ctrl(req_op);
         end
         ST_MUL: begin
            alu_a_d = hi_nxt;
            alu_b_d = lo_nxt[0] ? mid_nxt : '0;
            ctrl_d  = CTRL_ADD;
         end
`ifdef ALU_SEQ_DIV_EN
         ST_DIV: begin
            alu_a_d = {hi_nxt[WIDTH-2:0], mid_nxt[WIDTH-1]};
            alu_b_d = lo_nxt;
            ctrl_d  = CTRL_SUB;
         end
`endif
         default: ;
      endcase

      if ((state != ST_DONE) && (state_nxt == ST_DONE)) begin
         case (state)
            ST_EXEC, ST_MUL: begin
               res_d = alu_result;
               err_d = 1'b0;
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
               res_d = is_rem ? hi_nxt : mid_nxt;
               err_d = 1'b0;
            end
`endif
            default: begin
               // illegal opcode, or divide by zero when division is built in
               err_d = 1'b1;
               res_d = '0;
`ifdef ALU_SEQ_DIV_EN
               if (w_div)
                  res_d = (req_op == OP_REM) ? req_a : '1;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a         <= '0;
         alu_b         <= '0;
         alu_ainvert   <= 1'b0;
         alu_binvert   <= 1'b0;
         alu_carryin   <= 1'b0;
         alu_operation <= 3'd0;
         resp_result   <= '0;
         resp_err      <= 1'b0;
         resp_valid    <= 1'b0;
         req_ready     <= 1'b0;
      end else begin
         alu_a         <= alu_a_d;
         alu_b         <= alu_b_d;
         alu_ainvert   <= ctrl_d.ainvert;
         alu_binvert   <= ctrl_d.binvert;
         alu_carryin   <= ctrl_d.carryin;
         alu_operation <= ctrl_d.operation;
         resp_result   <= res_d;
         resp_err      <= err_d;
         resp_valid    <= valid_d;
         req_ready     <= ready_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_seq_ctrl : directed self-checking bench with a behavioural ALU.     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_alu_seq_ctrl;

   localparam int W = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_op = 4'd0;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic          alu_ainvert, alu_binvert, alu_carryin, alu_carryout;
   logic [2:0]    alu_operation;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [W-1:0]  resp_result;
   logic          resp_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WIDTH(W), .OPW(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_ainvert   (alu_ainvert),
      .alu_binvert   (alu_binvert),
      .alu_carryin   (alu_carryin),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .alu_carryout  (alu_carryout),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_result   (resp_result),
      .resp_err      (resp_err)
   );

   // Ripple ALU built from 1-bit slices, modelled at word level
   logic [W-1:0] m_a, m_b;
   logic [W:0]   m_sum;
   always_comb begin
      m_a   = alu_ainvert ? ~alu_a : alu_a;
      m_b   = alu_binvert ? ~alu_b : alu_b;
      m_sum = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, alu_carryin};
      case (alu_operation)
         3'd0:    alu_result = m_a & m_b;
         3'd1:    alu_result = m_a | m_b;
         3'd2:    alu_result = m_sum[W-1:0];
         3'd3:    alu_result = {{(W-1){1'b0}}, m_sum[W-1]};
         3'd4:    alu_result = m_a ^ m_b;
         default: alu_result = '0;
      endcase
      alu_carryout = m_sum[W];
   end

   function automatic logic [5:0] ctrl_tuple();
      return {alu_ainvert, alu_binvert, alu_carryin, alu_operation};
   endfunction

   function automatic logic [79:0] all_outs();
      return {resp_valid, resp_err, resp_result, alu_a, alu_b, ctrl_tuple()};
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready_wait", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      tick();
      req_valid = 1'b0;
   endtask

   // Call in the first cycle after the accepting edge
   task automatic get_resp(input string tag, input int lat, input logic [W-1:0] res, input logic err);
      int n = 1;
      while (!resp_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, resp_result, res);
      chk({tag, "_err"}, resp_err, err);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk({tag, "_drop"}, resp_valid, 0);
   endtask

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [5:0] ctrl;
   } vec_t;

   vec_t vecs[8] = '{
      '{"and",   4'd0, 24'h0F0F0F, 24'h00FFFF, 24'h000F0F, 6'h00},
      '{"or",    4'd1, 24'h0F0F0F, 24'h00FFFF, 24'h0FFFFF, 6'h01},
      '{"add",   4'd2, 24'hFFFFFF, 24'h000001, 24'h000000, 6'h02},
      '{"slt_t", 4'd4, 24'h000003, 24'h000005, 24'h000001, 6'h1B},
      '{"slt_f", 4'd4, 24'h000005, 24'h000003, 24'h000000, 6'h1B},
      '{"xor",   4'd5, 24'h0F0F0F, 24'h00FFFF, 24'h0FF0F0, 6'h04},
      '{"nor",   4'd6, 24'h0F0F0F, 24'h00FF00, 24'hF000F0, 6'h30},
      '{"sub_n", 4'd3, 24'h000010, 24'h000001, 24'h00000F, 6'h1A}
   };

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      #2 rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_outs", all_outs(), 80'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_low", req_ready, 0);
      tick();
      chk("rel_ready_high", req_ready, 1);

      // SUB with control and latency checks
      send(4'd3, 24'h000005, 24'h000007);
      chk("sub_ctrl", ctrl_tuple(), 6'h1A);
      chk("sub_alu_a", alu_a, 24'h000005);
      chk("sub_alu_b", alu_b, 24'h000007);
      chk("sub_not_yet", resp_valid, 0);
      get_resp("sub", 2, 24'hFFFFFE, 1'b0);
      chk("sub_ready_gap", req_ready, 0);
      tick();
      chk("sub_ready_back", req_ready, 1);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b);
         chk({vecs[i].name, "_ctrl"}, ctrl_tuple(), vecs[i].ctrl);
         get_resp(vecs[i].name, 2, vecs[i].r, 1'b0);
      end

      // MUL
      send(4'd7, 24'h000123, 24'h000045);
      chk("mul_first_a", alu_a, 24'h000000);
      chk("mul_first_b", alu_b, 24'h000123);
      chk("mul_first_ctrl", ctrl_tuple(), 6'h02);
      get_resp("mul", 25, 24'h004E6F, 1'b0);
      send(4'd7, 24'h800000, 24'h000002);
      get_resp("mul_ovf", 25, 24'h000000, 1'b0);
      send(4'd7, 24'hFFFFFF, 24'hFFFFFF);
      get_resp("mul_max", 25, 24'h000001, 1'b0);

      // illegal opcode
      send(4'hF, 24'h000001, 24'h000002);
      get_resp("ill_f", 1, 24'h000000, 1'b1);

`ifdef ALU_SEQ_DIV_EN
      send(4'd8, 24'd100, 24'd7);
      chk("div_first_ctrl", ctrl_tuple(), 6'h1A);
      chk("div_first_a", alu_a, 24'h000000);
      chk("div_first_b", alu_b, 24'd7);
      get_resp("div", 25, 24'd14, 1'b0);
      send(4'd9, 24'd100, 24'd7);
      get_resp("rem", 25, 24'd2, 1'b0);
      send(4'd8, 24'd5, 24'd0);
      get_resp("div0", 1, 24'hFFFFFF, 1'b1);
      send(4'd9, 24'd5, 24'd0);
      get_resp("rem0", 1, 24'd5, 1'b1);
`else
      send(4'd8, 24'd100, 24'd7);
      get_resp("ill_8", 1, 24'h000000, 1'b1);
      send(4'd9, 24'd100, 24'd7);
      get_resp("ill_9", 1, 24'h000000, 1'b1);
`endif

      // back-pressure: response held, stray request ignored
      send(4'd2, 24'd3, 24'd4);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", resp_valid, 1);
         chk("stall_res", resp_result, 24'd7);
         chk("stall_ready", req_ready, 0);
         chk("stall_alu_a", alu_a, 24'd0);
         if (i == 2) begin
            req_valid = 1'b1;
            req_op    = 4'd0;
            req_a     = 24'd0;
            req_b     = 24'd0;
         end
         if (i == 3) req_valid = 1'b0;
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("stall_drop", resp_valid, 0);
      repeat (3) begin
         tick();
         chk("stall_no_ghost", resp_valid, 0);
      end

      // reset during MUL iteration 10
      send(4'd7, 24'h000123, 24'h000045);
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", req_ready, 0);
      chk("midrst_outs", all_outs(), 80'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      send(4'd2, 24'd1, 24'd2);
      get_resp("add_after_rst", 2, 24'd3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
